pc_call_stack: RTL

Parametrised program counter for the processor datapath. Supports increment, absolute load from bus, signed relative branch, and call/return through an internal return-address LIFO. Drives the fetch address register every cycle. Flags stack overflow and underflow for the control unit.

---
 rtl/pc_pkg.sv | 35 +++
 rtl/return_stack.sv | 47 ++++
 rtl/pc_call_stack.sv | 86 ++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types for the program counter / call stack block.
// Holds the operation encoding and the strobe priority encoder.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_LOAD,
        PC_REL,
        PC_CALL,
        PC_RET
    } pc_op_t;

    // Strobe priority: stall > ret > call > load_en > rel_en > inc.
    // Reset sits above all of these and is handled in the registers.
    function automatic pc_op_t decode_op(
        input logic stall,
        input logic ret,
        input logic call,
        input logic load_en,
        input logic rel_en,
        input logic inc
    );
        pc_op_t op;
        if (stall)        op = PC_HOLD;
        else if (ret)     op = PC_RET;
        else if (call)    op = PC_CALL;
        else if (load_en) op = PC_LOAD;
        else if (rel_en)  op = PC_REL;
        else if (inc)     op = PC_INC;
        else              op = PC_HOLD;
        return op;
    endfunction

endpackage

// File: rtl/return_stack.sv
// Return-address LIFO with occupancy count.
// Push when full and pop when empty leave the stack untouched.
module return_stack #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !push && !empty;
    assign wr_idx  = AW'(count);
    assign top_idx = AW'(count - CW'(1));

    // Entry contents are don't-care after reset, so only the count is cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (do_push) begin
            mem[wr_idx] <= push_data;
            count       <= count + CW'(1);
        end else if (do_pop) begin
            count <= count - CW'(1);
        end
    end

    assign top_data = empty ? '0 : mem[top_idx];

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with increment, load, relative branch and call/return.
// Sticky overflow/underflow flags report misuse of the return stack.
module pc_call_stack
    import pc_pkg::*;
#(
    parameter int                PC_WIDTH     = 12,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
    parameter int                OFFSET_WIDTH = 8,
    parameter int                STACK_DEPTH  = 4,
    localparam int CW = $clog2(STACK_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    inc,
    input  logic                    load_en,
    input  logic                    rel_en,
    input  logic                    call,
    input  logic                    ret,
    input  logic                    clr_flags,
    input  logic [PC_WIDTH-1:0]     bus_data_in,
    input  logic [OFFSET_WIDTH-1:0] rel_offset,
    output logic [PC_WIDTH-1:0]     pc_out,
    output logic [CW-1:0]           stack_count,
    output logic                    stack_full,
    output logic                    stack_empty,
    output logic                    overflow_err,
    output logic                    underflow_err
);

    pc_op_t              op;
    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] pc_plus1;
    logic [PC_WIDTH-1:0] rel_ext;
    logic [PC_WIDTH-1:0] top_data;

    assign op       = decode_op(stall, ret, call, load_en, rel_en, inc);
    assign pc_plus1 = pc_out + PC_WIDTH'(1);
    assign rel_ext  = PC_WIDTH'($signed(rel_offset));

    return_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (op == PC_CALL),
        .pop       (op == PC_RET),
        .push_data (pc_plus1),
        .top_data  (top_data),
        .count     (stack_count),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    always_comb begin
        pc_next = pc_out;
        case (op)
            PC_INC:  pc_next = pc_plus1;
            PC_LOAD: pc_next = bus_data_in;
            PC_REL:  pc_next = pc_out + rel_ext;
            PC_CALL: pc_next = bus_data_in;
            PC_RET:  pc_next = stack_empty ? pc_out : top_data;
            default: pc_next = pc_out;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) pc_out <= RESET_PC;
        else       pc_out <= pc_next;
    end

    // A new error in the same cycle as clr_flags wins; stall freezes the flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else if (!stall) begin
            overflow_err  <= (overflow_err && !clr_flags)
                             || (op == PC_CALL && stack_full);
            underflow_err <= (underflow_err && !clr_flags)
                             || (op == PC_RET && stack_empty);
        end
    end

endmodule
